kyber_decap_sequencer: RTL and testbench

- Run-level controller for the Kyber_Server decapsulation core.
- On a host command it:
  - resets and starts the core;
  - streams the ciphertext from a word-addressed CT RAM into the core when the core requests it;
  - writes the core's output words into a result RAM;
  - reports done or error.
- Sits between the host register/RAM interface and the core.
- Replaces the free-running load/start/wen glue with a checked, k-aware sequencer.

---
 rtl/kyber_seq_pkg.sv | 33 +++
 rtl/kyber_decap_sequencer_if.sv | 47 ++++
 rtl/kyber_seq_timeout.sv | 36 +++
 rtl/kyber_decap_sequencer.sv | 160 ++++++++++++++++
 tb/tb_kyber_decap_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/kyber_seq_pkg.sv
// Shared types and helpers for the Kyber decapsulation run sequencer:
// FSM encoding, ciphertext lengths per k, and the legal-k test.
package kyber_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CRST    = 3'd1,
        CSTART  = 3'd2,
        WREQ    = 3'd3,
        FEED    = 3'd4,
        COLLECT = 3'd5,
        FIN     = 3'd6,
        ERR     = 3'd7
    } state_e;

    localparam logic [15:0] CT_WORDS_K2 = 16'd192;
    localparam logic [15:0] CT_WORDS_K3 = 16'd272;
    localparam logic [15:0] CT_WORDS_K4 = 16'd392;

    function automatic logic k_legal(input logic [2:0] k);
        return (k == 3'd2) || (k == 3'd3) || (k == 3'd4);
    endfunction

    // Only meaningful for legal k; anything else falls through to the k=4 length.
    function automatic logic [15:0] ct_words(input logic [2:0] k);
        case (k)
            3'd2:    return CT_WORDS_K2;
            3'd3:    return CT_WORDS_K3;
            default: return CT_WORDS_K4;
        endcase
    endfunction

endpackage

// File: rtl/kyber_decap_sequencer_if.sv
// Host, CT RAM, core and result RAM signals of the sequencer in one bundle.
// Handshake: cmd_start is a one-cycle request accepted only in IDLE; core_req_c/core_valid are single-cycle qualifiers sampled on clk.
interface kyber_decap_sequencer_if #(
    parameter int unsigned CT_AW  = 9,
    parameter int unsigned RES_AW = 6
);
    import kyber_seq_pkg::*;

    logic              cmd_start;
    logic [2:0]        cmd_k;
    logic              busy;
    logic              done;
    logic              err_timeout;
    logic              err_kbad;
    logic              ct_rd_en;
    logic [CT_AW-1:0]  ct_rd_addr;
    logic [31:0]       ct_rd_data;
    logic              core_rst;
    logic              core_start;
    logic [2:0]        core_k;
    logic              core_ready_c;
    logic              core_req_c;
    logic              core_wen;
    logic [31:0]       core_din;
    logic              core_valid;
    logic [31:0]       core_dout;
    logic              res_wr_en;
    logic [RES_AW-1:0] res_wr_addr;
    logic [31:0]       res_wr_data;
    logic [CT_AW-1:0]  ct_count;
    state_e            dbg_state;

    modport master (
        input  cmd_start, cmd_k, ct_rd_data, core_req_c, core_valid, core_dout,
        output busy, done, err_timeout, err_kbad, ct_rd_en, ct_rd_addr,
               core_rst, core_start, core_k, core_ready_c, core_wen, core_din,
               res_wr_en, res_wr_addr, res_wr_data, ct_count, dbg_state
    );

    modport slave (
        output cmd_start, cmd_k, ct_rd_data, core_req_c, core_valid, core_dout,
        input  busy, done, err_timeout, err_kbad, ct_rd_en, ct_rd_addr,
               core_rst, core_start, core_k, core_ready_c, core_wen, core_din,
               res_wr_en, res_wr_addr, res_wr_data, ct_count, dbg_state
    );

endinterface

// File: rtl/kyber_seq_timeout.sv
// Saturating wait counter: counts enabled cycles, clears on request,
// and flags the cycle on which the count reaches LIMIT.
module kyber_seq_timeout #(
    parameter int unsigned LIMIT = 1048576
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CW'(LIMIT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the enabled cycle that would bring the count to LIMIT.
    assign expired = en && (cnt_q >= CW'(LIMIT - 1));

endmodule

// File: rtl/kyber_decap_sequencer.sv
// Run-level controller for the Kyber decapsulation core: resets/starts the core,
// streams the k-sized ciphertext, collects result words, reports done/error.
module kyber_decap_sequencer
    import kyber_seq_pkg::*;
#(
    parameter int unsigned RES_WORDS      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned CT_AW          = 9,
    parameter int unsigned RES_AW         = 6
) (
    input logic clk,
    input logic rst,
    kyber_decap_sequencer_if.master bus
);
    localparam int unsigned RIW = $clog2(RES_WORDS + 1);

    state_e           state_q, state_d;
    logic [2:0]       k_q, k_d;
    logic [CT_AW-1:0] last_addr_q, last_addr_d;
    logic [CT_AW-1:0] rd_addr_q, rd_addr_d;
    logic [CT_AW-1:0] ct_count_q, ct_count_d;
    logic [RIW-1:0]   res_idx_q, res_idx_d;
    logic             wen_q, wen_d;
    logic             err_kbad_q, err_kbad_d;
    logic             err_timeout_q, err_timeout_d;
    logic             kbad_done_q, kbad_done_d;

    logic in_run, capture, wait_en, wait_clr, expired;

    assign in_run  = (state_q == WREQ) || (state_q == FEED) || (state_q == COLLECT);
    // Result words are accepted from WREQ onwards; anything past RES_WORDS is dropped.
    assign capture = in_run && bus.core_valid && (res_idx_q < RIW'(RES_WORDS));
    assign wait_en = ((state_q == WREQ) && !bus.core_req_c) ||
                     ((state_q == COLLECT) && !bus.core_valid);
    assign wait_clr = (state_d != state_q) || ((state_q == COLLECT) && bus.core_valid);

    kyber_seq_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (wait_clr),
        .en      (wait_en),
        .expired (expired)
    );

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        last_addr_d   = last_addr_q;
        rd_addr_d     = rd_addr_q;
        ct_count_d    = ct_count_q;
        res_idx_d     = res_idx_q;
        err_kbad_d    = err_kbad_q;
        err_timeout_d = err_timeout_q;
        kbad_done_d   = 1'b0;
        wen_d         = (state_q == FEED);

        if (capture) begin
            res_idx_d = res_idx_q + RIW'(1);
        end
        if (wen_q) begin
            ct_count_d = ct_count_q + CT_AW'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_start) begin
                    if (k_legal(bus.cmd_k)) begin
                        state_d       = CRST;
                        k_d           = bus.cmd_k;
                        last_addr_d   = CT_AW'(ct_words(bus.cmd_k) - 16'd1);
                        rd_addr_d     = '0;
                        ct_count_d    = '0;
                        res_idx_d     = '0;
                        err_kbad_d    = 1'b0;
                        err_timeout_d = 1'b0;
                    end else begin
                        err_kbad_d  = 1'b1;
                        kbad_done_d = 1'b1;
                    end
                end
            end
            CRST:   state_d = CSTART;
            CSTART: state_d = WREQ;
            WREQ: begin
                if (bus.core_req_c) begin
                    state_d = FEED;
                end else if (expired) begin
                    state_d = ERR;
                end
            end
            FEED: begin
                // The address holds at N-1 after the final read.
                if (rd_addr_q == last_addr_q) begin
                    state_d = COLLECT;
                end else begin
                    rd_addr_d = rd_addr_q + CT_AW'(1);
                end
            end
            COLLECT: begin
                if (res_idx_d == RIW'(RES_WORDS)) begin
                    state_d = FIN;
                end else if (expired) begin
                    state_d = ERR;
                end
            end
            FIN:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if ((state_d == ERR) && (state_q != ERR)) begin
            err_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            k_q           <= '0;
            last_addr_q   <= '0;
            rd_addr_q     <= '0;
            ct_count_q    <= '0;
            res_idx_q     <= '0;
            wen_q         <= 1'b0;
            err_kbad_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            kbad_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            last_addr_q   <= last_addr_d;
            rd_addr_q     <= rd_addr_d;
            ct_count_q    <= ct_count_d;
            res_idx_q     <= res_idx_d;
            wen_q         <= wen_d;
            err_kbad_q    <= err_kbad_d;
            err_timeout_q <= err_timeout_d;
            kbad_done_q   <= kbad_done_d;
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == FIN) || (state_q == ERR) || kbad_done_q;
    assign bus.err_timeout  = err_timeout_q;
    assign bus.err_kbad     = err_kbad_q;
    assign bus.ct_rd_en     = (state_q == FEED);
    assign bus.ct_rd_addr   = rd_addr_q;
    assign bus.core_rst     = rst || (state_q == CRST) || (state_q == ERR);
    assign bus.core_start   = (state_q == CSTART);
    assign bus.core_k       = k_q;
    assign bus.core_ready_c = in_run;
    assign bus.core_wen     = wen_q;
    assign bus.core_din     = bus.ct_rd_data;
    assign bus.res_wr_en    = capture;
    assign bus.res_wr_addr  = RES_AW'(res_idx_q);
    assign bus.res_wr_data  = bus.core_dout;
    assign bus.ct_count     = ct_count_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_kyber_decap_sequencer.sv
// Directed bench for kyber_decap_sequencer: CT RAM and core models,
// expected-queue scoreboard checked by a negedge monitor.
module tb_kyber_decap_sequencer;
    import kyber_seq_pkg::*;

    localparam int unsigned TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kyber_decap_sequencer_if #(.CT_AW(9), .RES_AW(6)) bus ();

    kyber_decap_sequencer #(
        .RES_WORDS(8), .TIMEOUT_CYCLES(TO), .CT_AW(9), .RES_AW(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_ct_q[$];
    logic [37:0] exp_res_q[$];

    int wen_run_cur, wen_run_max, wen_total, rd_cnt, rd_last, rd_max;
    int start_cnt, crst_cnt, err_rst_cnt, done_cnt, wreq_cycles, busy_seen;

    function automatic logic [31:0] ct_word(input int i);
        return {16'hC7C7, i[15:0]};
    endfunction

    function automatic logic [31:0] res_word(input int j);
        return {16'h5EC0, j[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        wen_run_cur = 0; wen_run_max = 0; wen_total = 0;
        rd_cnt = 0; rd_last = -1; rd_max = -1;
        start_cnt = 0; crst_cnt = 0; err_rst_cnt = 0;
        done_cnt = 0; wreq_cycles = 0; busy_seen = 0;
    endtask

    // CT RAM: one-cycle read latency
    always @(posedge clk) begin
        if (bus.ct_rd_en) bus.ct_rd_data <= ct_word(int'(bus.ct_rd_addr));
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.core_wen === 1'b1) begin
                wen_total++;
                wen_run_cur++;
                if (wen_run_cur > wen_run_max) wen_run_max = wen_run_cur;
                if (exp_ct_q.size() == 0) check("wen_unexpected", 64'd1, 64'd0);
                else check("core_din", 64'(bus.core_din), 64'(exp_ct_q.pop_front()));
            end else begin
                wen_run_cur = 0;
            end
            if (bus.ct_rd_en) begin
                rd_cnt++;
                rd_last = int'(bus.ct_rd_addr);
                if (rd_last > rd_max) rd_max = rd_last;
            end
            if (bus.res_wr_en === 1'b1) begin
                if (exp_res_q.size() == 0) check("res_wr_unexpected", 64'd1, 64'd0);
                else check("res_wr", 64'({bus.res_wr_addr, bus.res_wr_data}), 64'(exp_res_q.pop_front()));
            end
            if (bus.core_start) start_cnt++;
            if (bus.core_rst) crst_cnt++;
            if (bus.core_rst && bus.dbg_state == ERR) err_rst_cnt++;
            if (bus.done) done_cnt++;
            if (bus.busy) busy_seen++;
            if (bus.dbg_state == WREQ) wreq_cycles++;
        end
    end

    task automatic issue_start(input logic [2:0] k);
        step();
        bus.cmd_k = k;
        bus.cmd_start = 1'b1;
        step();
        bus.cmd_start = 1'b0;
    endtask

    task automatic wait_core_start();
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.core_start) begin seen = 1; break; end
            step();
        end
        check("core_start_seen", 64'(seen), 64'd1);
    endtask

    task automatic do_run(input int k, input int n, input int req_delay,
                          input int n_valid, input bit extra_start);
        bit seen;
        int nexp;
        clear_stats();
        for (int i = 0; i < n; i++) exp_ct_q.push_back(ct_word(i));
        nexp = (n_valid < 8) ? n_valid : 8;
        for (int j = 0; j < nexp; j++) exp_res_q.push_back({6'(j), res_word(j)});

        issue_start(3'(k));
        check("err_timeout_cleared", 64'(bus.err_timeout), 64'd0);
        check("err_kbad_cleared", 64'(bus.err_kbad), 64'd0);
        wait_core_start();
        repeat (req_delay) step();
        bus.core_req_c = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.ct_rd_en) begin seen = 1; break; end
            step();
        end
        check("feed_entered", 64'(seen), 64'd1);
        bus.core_req_c = 1'b0;
        seen = 0;
        for (int i = 0; i < n + 20; i++) begin
            if (!bus.ct_rd_en) begin seen = 1; break; end
            step();
        end
        check("feed_left", 64'(seen), 64'd1);

        for (int j = 0; j < n_valid; j++) begin
            bus.core_valid = 1'b1;
            bus.core_dout = res_word(j);
            if (j == 0 && extra_start) begin
                bus.cmd_k = 3'd3;
                bus.cmd_start = 1'b1;
            end
            step();
            bus.core_valid = 1'b0;
            bus.cmd_start = 1'b0;
            step();
        end
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.busy) begin seen = 1; break; end
            step();
        end
        check("run_finished", 64'(seen), 64'd1);
        repeat (4) step();

        check("wen_consecutive", 64'(wen_run_max), 64'(n));
        check("wen_total", 64'(wen_total), 64'(n));
        check("rd_count", 64'(rd_cnt), 64'(n));
        check("rd_last_addr", 64'(rd_last), 64'(n - 1));
        check("rd_max_addr", 64'(rd_max), 64'(n - 1));
        check("ct_count", 64'(bus.ct_count), 64'(n));
        check("core_k", 64'(bus.core_k), 64'(k));
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("core_start_pulses", 64'(start_cnt), 64'd1);
        check("core_rst_cycles", 64'(crst_cnt), 64'd1);
        check("busy_idle", 64'(bus.busy), 64'd0);
        check("ct_queue_empty", 64'(exp_ct_q.size()), 64'd0);
        check("res_queue_empty", 64'(exp_res_q.size()), 64'd0);
        check("err_timeout_run", 64'(bus.err_timeout), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_start = 1'b0;
        bus.cmd_k = 3'd0;
        bus.core_req_c = 1'b0;
        bus.core_valid = 1'b0;
        bus.core_dout = 32'h0;
        clear_stats();

        // Reset values
        rst = 1'b1;
        repeat (3) step();
        check("rst_core_rst", 64'(bus.core_rst), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_errs", 64'({bus.err_timeout, bus.err_kbad}), 64'd0);
        check("rst_ct_count", 64'(bus.ct_count), 64'd0);
        check("rst_strobes", 64'({bus.ct_rd_en, bus.core_wen, bus.core_start, bus.core_ready_c}), 64'd0);
        check("rst_state", 64'(bus.dbg_state), 64'(IDLE));
        rst = 1'b0;
        step();
        check("core_rst_released", 64'(bus.core_rst), 64'd0);

        // Illegal k
        clear_stats();
        issue_start(3'd5);
        check("kbad_done", 64'(bus.done), 64'd1);
        check("kbad_flag", 64'(bus.err_kbad), 64'd1);
        repeat (4) step();
        check("kbad_done_pulses", 64'(done_cnt), 64'd1);
        check("kbad_busy", 64'(busy_seen), 64'd0);
        check("kbad_no_start", 64'(start_cnt), 64'd0);
        check("kbad_no_core_rst", 64'(crst_cnt), 64'd0);
        check("kbad_sticky", 64'(bus.err_kbad), 64'd1);

        // k=2 nominal, k=4 with excess valids and a start while busy
        do_run(2, 192, 5, 8, 1'b0);
        do_run(4, 392, 3, 10, 1'b1);

        // Core never requests ciphertext
        clear_stats();
        issue_start(3'd2);
        for (int i = 0; i < 200; i++) begin
            if (!bus.busy) break;
            step();
        end
        repeat (3) step();
        check("to_wreq_cycles", 64'(wreq_cycles), 64'(TO));
        check("to_err_timeout", 64'(bus.err_timeout), 64'd1);
        check("to_done_pulses", 64'(done_cnt), 64'd1);
        check("to_err_core_rst", 64'(err_rst_cnt), 64'd1);
        check("to_core_rst_total", 64'(crst_cnt), 64'd2);
        check("to_no_wen", 64'(wen_total), 64'd0);
        check("to_busy", 64'(bus.busy), 64'd0);

        // Legal start after timeout clears the error
        do_run(3, 272, 2, 8, 1'b0);

        // Reset in the middle of FEED
        clear_stats();
        for (int i = 0; i < 272; i++) exp_ct_q.push_back(ct_word(i));
        issue_start(3'd3);
        wait_core_start();
        bus.core_req_c = 1'b1;
        begin
            bit seen = 0;
            for (int i = 0; i < 300; i++) begin
                if (bus.ct_rd_en && bus.ct_rd_addr == 9'd100) begin seen = 1; break; end
                step();
            end
            check("feed_word_100", 64'(seen), 64'd1);
        end
        bus.core_req_c = 1'b0;
        rst = 1'b1;
        step();
        check("mid_rst_state", 64'(bus.dbg_state), 64'(IDLE));
        check("mid_rst_core_rst", 64'(bus.core_rst), 64'd1);
        check("mid_rst_strobes", 64'({bus.core_wen, bus.ct_rd_en, bus.busy}), 64'd0);
        check("mid_rst_done", 64'(bus.done), 64'd0);
        rst = 1'b0;
        exp_ct_q.delete();
        done_cnt = 0;
        repeat (3) step();
        check("mid_rst_no_done", 64'(done_cnt), 64'd0);
        check("mid_rst_ct_count", 64'(bus.ct_count), 64'd0);

        // Recovery run
        do_run(2, 192, 1, 8, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
